delay_line_param: RTL and testbench
===================================

DELAY_LINE_PARAM -- requirements
Module: delay_line_param

Interface
REQ-001 Parameter WIDTH, default 8, bits per channel sample.
REQ-002 Parameter DEPTH, default 32, maximum delay span in steps; power of two, 2..256.
REQ-003 Parameter CHANNELS, default 2, independent delay channels sharing one write timeline.
REQ-004 Localparam AW = log2(DEPTH), delay field width.
REQ-005 clk_Signal  input  1  signal unit clock; all logic on rising edge.
REQ-006 Rst  input  1  reset; synchronous, active-high.
REQ-007 Shift_En  input  1  step enable; high at an edge = one step; the sample is accepted.
REQ-008 Data_In  input  CHANNELS*WIDTH  samples; channel c in bits [c*WIDTH +: WIDTH].
REQ-009 Delay_Load  input  CHANNELS  per-channel pulse; captures that channel's Delay_Cfg field.
REQ-010 Delay_Cfg  input  CHANNELS*AW  requested delay D per channel, 0..DEPTH-1.
REQ-011 Data_Out  output  CHANNELS*WIDTH  delayed samples, registered.
REQ-012 Valid_Out  output  CHANNELS  channel output carries real history, registered.
REQ-013 Delay_Cur  output  CHANNELS*AW  currently applied delay per channel.

Function
REQ-014 Buffer SHALL be a circular array of DEPTH entries per channel, indexed by one shared write pointer wp (AW bits).
REQ-015 On each step, each channel SHALL write its Data_In slice at wp; wp SHALL then increment and wrap from DEPTH-1 to 0.
REQ-016 On each step, each channel SHALL update Data_Out with the sample accepted D steps earlier. D=0 returns the current step's sample, giving a one-clock latency. The read address is (wp - D) mod DEPTH, computed before the increment, with the write bypassed when D=0.
REQ-017 Fill counter F SHALL count steps since reset, saturating at DEPTH-1.
REQ-018 On each step, Valid_Out[c] SHALL be set to (F >= D_c), using F before the increment. When invalid, Data_Out[c] SHALL be set to 0.
REQ-019 When Shift_En is low, Data_Out, Valid_Out, wp and F SHALL hold; no write occurs.
REQ-020 Delay_Load[c] SHALL update D_c, and hence Delay_Cur[c], at that edge. A step in the same cycle SHALL use the new D_c.
REQ-021 A delay change SHALL NOT flush history. Validity after the change is determined by F alone, per REQ-018.
REQ-022 Channels SHALL be fully independent except for the shared wp and F.
REQ-023 Address arithmetic SHALL be AW-bit modulo DEPTH; no out-of-range read is possible.

Reset
REQ-024 On Rst high at an edge: wp=0, F=0, all buffer entries=0, Data_Out=0, Valid_Out=0, every D_c=0 and Delay_Cur=0.
REQ-025 Rst SHALL override Shift_En and Delay_Load in the same cycle.
REQ-026 Reset mid-operation SHALL discard all history. The first post-reset step with D=0 SHALL yield Valid_Out=1.

Structure
REQ-027 Shared package delay_line_pkg SHALL hold the clog2 function and the default WIDTH, DEPTH and CHANNELS constants.
REQ-028 Sub-module delay_line_chan SHALL hold one channel's storage, D register, read mux and output register; the top SHALL generate CHANNELS instances.
REQ-029 Top level SHALL hold wp, F and the reset and step distribution.

Verification
REQ-030 Defaults; D=0 on ch0; Shift_En held high; Data_In ch0 = 1,2,3 -> Data_Out ch0 = 1,2,3 one clock later, Valid_Out=1 from the first step.
REQ-031 D=5 on ch1; ramp 10,11,... with one sample per step -> Valid_Out[1]=0 for the first 5 steps with Data_Out=0, then Data_Out=10 on step 6 and continuing.
REQ-032 D=31 on ch0 -> Valid_Out[0] rises on step 32, Data_Out equals the step-1 sample; wp wrap is exercised with 70 steps, no glitch at 31->0.
REQ-033 Shift_En low for 4 cycles mid-stream -> outputs and Delay_Cur frozen; the stream resumes without a lost or duplicated sample.
REQ-034 After 40 steps, load D=3 while stepping on ch0 -> the same-edge output is the sample from 3 steps earlier, Valid_Out stays 1.
REQ-035 Assert Rst in the middle of REQ-031, with Delay_Load high in the same cycle -> all outputs 0, Delay_Cur=0; the next step with D=0 gives Valid_Out=1.

Source files
------------

// File: rtl/delay_line_pkg.sv
// ---------------------------------------------------------------------------
// delay_line_pkg
// Shared constants and helpers for the parameterised multi-channel delay line.
//   DEFAULT_WIDTH    : default bits per channel sample
//   DEFAULT_DEPTH    : default delay span (power of two)
//   DEFAULT_CHANNELS : default number of independent channels
//   clog2()          : ceiling log2, used to size the delay/pointer fields
// ---------------------------------------------------------------------------
package delay_line_pkg;

  localparam int DEFAULT_WIDTH    = 8;
  localparam int DEFAULT_DEPTH    = 32;
  localparam int DEFAULT_CHANNELS = 2;

  // Ceiling log2; returns at least 1 so a field is never zero bits wide.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    if (result < 1) begin
      result = 1;
    end
    return result;
  endfunction

endpackage : delay_line_pkg

// File: rtl/delay_line_chan.sv
// ---------------------------------------------------------------------------
// delay_line_chan
// One channel of the delay line: circular sample storage, the applied delay
// register, the read mux and the registered output stage.
// Ports:
//   clk, srst      : clock and synchronous active-high reset
//   step           : one step of the shared timeline (sample accepted)
//   wr_ptr         : shared write pointer, value before this step's increment
//   fill           : shared fill count, value before this step's increment
//   sample_in      : this channel's input sample
//   delay_load     : pulse to capture delay_cfg into the delay register
//   delay_cfg      : requested delay
//   sample_out     : registered delayed sample (0 while invalid)
//   valid_out      : registered flag, output carries real history
//   delay_cur      : currently applied delay
// ---------------------------------------------------------------------------
module delay_line_chan
  import delay_line_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH,
  parameter int AW    = clog2(DEFAULT_DEPTH)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             step,
  input  logic [AW-1:0]    wr_ptr,
  input  logic [AW-1:0]    fill,
  input  logic [WIDTH-1:0] sample_in,
  input  logic             delay_load,
  input  logic [AW-1:0]    delay_cfg,
  output logic [WIDTH-1:0] sample_out,
  output logic             valid_out,
  output logic [AW-1:0]    delay_cur
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    delay_q;
  logic [AW-1:0]    delay_d;
  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;
  logic             valid_q;
  logic             valid_d;

  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_sample;

  always_comb begin
    // A load in the same cycle as a step is applied to that step.
    delay_d = delay_load ? delay_cfg : delay_q;

    // AW-bit subtraction wraps modulo DEPTH, so the address is always in range.
    rd_addr = wr_ptr - delay_d;

    // With zero delay the wanted sample is the one being written right now,
    // which is not in the array yet, so it is taken straight from the input.
    if (delay_d == '0) begin
      rd_sample = sample_in;
    end else begin
      rd_sample = mem_q[rd_addr];
    end

    valid_d = valid_q;
    data_d  = data_q;
    if (step) begin
      valid_d = (fill >= delay_d);
      data_d  = valid_d ? rd_sample : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      delay_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      delay_q <= delay_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      if (step) begin
        mem_q[wr_ptr] <= sample_in;
      end
    end
  end

  assign sample_out = data_q;
  assign valid_out  = valid_q;
  assign delay_cur  = delay_q;

endmodule : delay_line_chan

// File: rtl/delay_line_param.sv
// ---------------------------------------------------------------------------
// delay_line_param
// Multi-channel programmable delay line. All channels share one write
// timeline (write pointer and fill counter); each channel has its own storage
// and delay setting.
// Ports:
//   clk_Signal : clock, rising edge
//   Rst        : synchronous active-high reset
//   Shift_En   : step enable, one accepted sample per channel per high edge
//   Data_In    : CHANNELS samples, channel c in [c*WIDTH +: WIDTH]
//   Delay_Load : per-channel pulse capturing the matching Delay_Cfg field
//   Delay_Cfg  : per-channel requested delay, channel c in [c*AW +: AW]
//   Data_Out   : registered delayed samples
//   Valid_Out  : registered per-channel history-valid flags
//   Delay_Cur  : currently applied per-channel delays
// ---------------------------------------------------------------------------
module delay_line_param
  import delay_line_pkg::*;
#(
  parameter  int WIDTH    = DEFAULT_WIDTH,
  parameter  int DEPTH    = DEFAULT_DEPTH,
  parameter  int CHANNELS = DEFAULT_CHANNELS,
  localparam int AW       = clog2(DEPTH)
) (
  input  logic                      clk_Signal,
  input  logic                      Rst,
  input  logic                      Shift_En,
  input  logic [CHANNELS*WIDTH-1:0] Data_In,
  input  logic [CHANNELS-1:0]       Delay_Load,
  input  logic [CHANNELS*AW-1:0]    Delay_Cfg,
  output logic [CHANNELS*WIDTH-1:0] Data_Out,
  output logic [CHANNELS-1:0]       Valid_Out,
  output logic [CHANNELS*AW-1:0]    Delay_Cur
);

  localparam logic [AW-1:0] FILL_MAX = AW'(DEPTH - 1);

  logic [AW-1:0] wp_q;
  logic [AW-1:0] wp_d;
  logic [AW-1:0] fill_q;
  logic [AW-1:0] fill_d;

  always_comb begin
    wp_d   = wp_q;
    fill_d = fill_q;
    if (Shift_En) begin
      // DEPTH is a power of two, so the natural AW-bit wrap is DEPTH-1 -> 0.
      wp_d = wp_q + 1'b1;
      if (fill_q != FILL_MAX) begin
        fill_d = fill_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_Signal) begin
    if (Rst) begin
      wp_q   <= '0;
      fill_q <= '0;
    end else begin
      wp_q   <= wp_d;
      fill_q <= fill_d;
    end
  end

  // Channels see the pre-increment pointer and fill count of the current step.
  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    delay_line_chan #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
    ) u_chan (
      .clk        (clk_Signal),
      .srst       (Rst),
      .step       (Shift_En),
      .wr_ptr     (wp_q),
      .fill       (fill_q),
      .sample_in  (Data_In[gi*WIDTH +: WIDTH]),
      .delay_load (Delay_Load[gi]),
      .delay_cfg  (Delay_Cfg[gi*AW +: AW]),
      .sample_out (Data_Out[gi*WIDTH +: WIDTH]),
      .valid_out  (Valid_Out[gi]),
      .delay_cur  (Delay_Cur[gi*AW +: AW])
    );
  end

endmodule : delay_line_param

// File: tb/tb_delay_line_param.sv
// ---------------------------------------------------------------------------
// tb_delay_line_param
// Scoreboard bench for delay_line_param. The driver keeps a plain history of
// every accepted input vector since reset and, for each step, pushes the
// expected outputs (sample taken D steps back, valid when at least D steps
// have occurred since reset). A monitor pops and compares after each edge.
// ---------------------------------------------------------------------------
module tb_delay_line_param;

  localparam int W     = 8;
  localparam int DEPTH = 32;
  localparam int CH    = 2;
  localparam int AW    = 5;

  typedef struct {
    logic [CH*W-1:0] data;
    logic [CH-1:0]   valid;
  } exp_t;

  logic              clk_Signal;
  logic              Rst;
  logic              Shift_En;
  logic [CH*W-1:0]   Data_In;
  logic [CH-1:0]     Delay_Load;
  logic [CH*AW-1:0]  Delay_Cfg;
  logic [CH*W-1:0]   Data_Out;
  logic [CH-1:0]     Valid_Out;
  logic [CH*AW-1:0]  Delay_Cur;

  delay_line_param #(
    .WIDTH    (W),
    .DEPTH    (DEPTH),
    .CHANNELS (CH)
  ) dut (
    .clk_Signal (clk_Signal),
    .Rst        (Rst),
    .Shift_En   (Shift_En),
    .Data_In    (Data_In),
    .Delay_Load (Delay_Load),
    .Delay_Cfg  (Delay_Cfg),
    .Data_Out   (Data_Out),
    .Valid_Out  (Valid_Out),
    .Delay_Cur  (Delay_Cur)
  );

  initial clk_Signal = 1'b0;
  always #5 clk_Signal = ~clk_Signal;

  // Reference model state
  logic [CH*W-1:0]  hist[$];
  int               steps_since_reset;
  logic [CH*AW-1:0] exp_dcur;
  exp_t             exp_q[$];

  int checks;
  int errors;
  int txn;

  // Monitor state
  logic            mon_step;
  logic            mon_rst;
  logic [CH*W-1:0] last_data;
  logic [CH-1:0]   last_valid;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (txn %0d)", name, act, req, txn);
    end
  endtask

  // Drive one clock cycle of inputs and advance the model to the post-edge state.
  task automatic cycle(input logic rst, input logic step, input logic [CH-1:0] load,
                       input logic [CH*AW-1:0] cfg, input logic [CH*W-1:0] din);
    exp_t e;
    logic [CH*W-1:0] past;
    int dc;
    int n;
    @(negedge clk_Signal);
    Rst        = rst;
    Shift_En   = step;
    Delay_Load = load;
    Delay_Cfg  = cfg;
    Data_In    = din;
    if (rst) begin
      hist.delete();
      steps_since_reset = 0;
      exp_dcur = '0;
    end else begin
      for (int c = 0; c < CH; c++) begin
        if (load[c]) exp_dcur[c*AW +: AW] = cfg[c*AW +: AW];
      end
      if (step) begin
        hist.push_back(din);
        n = hist.size();
        e.data  = '0;
        e.valid = '0;
        for (int c = 0; c < CH; c++) begin
          dc = int'(exp_dcur[c*AW +: AW]);
          // Valid once at least D samples preceded this one since reset.
          if (steps_since_reset >= dc) begin
            past = hist[n-1-dc];
            e.valid[c] = 1'b1;
            e.data[c*W +: W] = past[c*W +: W];
          end
        end
        exp_q.push_back(e);
        steps_since_reset++;
        if (hist.size() > DEPTH + 2) void'(hist.pop_front());
      end
    end
  endtask

  task automatic step1(input logic [CH*W-1:0] din);
    cycle(1'b0, 1'b1, '0, '0, din);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, '0, '0, '0);
  endtask

  function automatic logic [CH*W-1:0] rnd_din();
    logic [CH*W-1:0] v;
    for (int c = 0; c < CH; c++) v[c*W +: W] = W'($urandom_range(0, 255));
    return v;
  endfunction

  // Monitor: compares after every edge, popping the scoreboard on steps.
  always @(posedge clk_Signal) begin
    exp_t e;
    mon_step = Shift_En;
    mon_rst  = Rst;
    #1;
    txn++;
    if (mon_rst) begin
      check("reset_data", 64'(Data_Out), 64'(0));
      check("reset_valid", 64'(Valid_Out), 64'(0));
      check("reset_dcur", 64'(Delay_Cur), 64'(0));
      exp_q.delete();
      last_data  = '0;
      last_valid = '0;
      $display("txn %0d reset", txn);
    end else begin
      if (mon_step) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: got step, expected no entry (txn %0d)", txn);
        end else begin
          e = exp_q.pop_front();
          check("step_data", 64'(Data_Out), 64'(e.data));
          check("step_valid", 64'(Valid_Out), 64'(e.valid));
          last_data  = e.data;
          last_valid = e.valid;
        end
      end else begin
        check("hold_data", 64'(Data_Out), 64'(last_data));
        check("hold_valid", 64'(Valid_Out), 64'(last_valid));
      end
      check("delay_cur", 64'(Delay_Cur), 64'(exp_dcur));
      $display("txn %0d step=%b din=%h dout=%h valid=%b dcur=%h",
               txn, mon_step, Data_In, Data_Out, Valid_Out, Delay_Cur);
    end
  end

  initial begin
    logic [CH*AW-1:0] cfg;
    logic [CH-1:0]    ld;
    checks = 0;
    errors = 0;
    txn    = 0;
    steps_since_reset = 0;
    exp_dcur   = '0;
    last_data  = '0;
    last_valid = '0;
    Rst        = 1'b1;
    Shift_En   = 1'b0;
    Delay_Load = '0;
    Delay_Cfg  = '0;
    Data_In    = '0;

    cycle(1'b1, 1'b0, '0, '0, '0);
    cycle(1'b1, 1'b0, '0, '0, '0);

    // D=0 on ch0: outputs 1,2,3 one clock later, valid from the first step.
    for (int i = 1; i <= 3; i++) step1({8'hA0 + 8'(i), 8'(i)});
    idle();

    // D=5 on ch1 with a ramp, then reset mid-stream with load and step high.
    cycle(1'b1, 1'b0, '0, '0, '0);
    cycle(1'b0, 1'b0, 2'b10, {5'd5, 5'd0}, '0);
    for (int i = 0; i < 8; i++) step1({8'(10 + i), 8'(i)});
    cycle(1'b1, 1'b1, 2'b11, {5'd7, 5'd9}, 16'hFFFF);
    step1(16'h5A3C);
    step1(16'h1234);

    // D=31 on ch0, 70 steps to cover the pointer wrap.
    cycle(1'b1, 1'b0, '0, '0, '0);
    cycle(1'b0, 1'b0, 2'b01, {5'd0, 5'd31}, '0);
    for (int i = 0; i < 70; i++) step1(rnd_din());

    // Shift_En low for 4 cycles mid-stream, then resume.
    for (int i = 0; i < 4; i++) idle();
    for (int i = 0; i < 10; i++) step1(rnd_din());

    // 40 steps, then load D=3 on ch0 on a stepping edge.
    cycle(1'b1, 1'b0, '0, '0, '0);
    for (int i = 0; i < 40; i++) step1(rnd_din());
    cycle(1'b0, 1'b1, 2'b01, {5'd0, 5'd3}, rnd_din());
    for (int i = 0; i < 5; i++) step1(rnd_din());

    // Randomised traffic with occasional loads and rare resets.
    for (int i = 0; i < 400; i++) begin
      ld  = ($urandom_range(0, 9) == 0) ? CH'($urandom_range(1, 3)) : '0;
      cfg = {5'($urandom_range(0, DEPTH-1)), 5'($urandom_range(0, DEPTH-1))};
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), ld, cfg, rnd_din());
    end

    idle();
    idle();
    check("scoreboard_drained", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_delay_line_param
